// File: rtl/frame_padder.sv
// frame_padder: wraps a WIDTH x HEIGHT raster frame in a one-pixel border,
// producing a (WIDTH+2) x (HEIGHT+2) frame for a downstream 3x3 window.
// Border beats are generated internally. The source is stalled only while
// border beats are emitted or while the output register is blocked.
// Optional build macro FRAME_PADDER_BORDER_VAL_EN adds an iBorder input. Its
// value is captured at the start of each frame and used as the border colour.
// When the macro is not defined, the border colour is 0.
module frame_padder #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int DW     = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          iValid,
    output logic          iReady,
    input  logic [DW-1:0] iData,
`ifdef FRAME_PADDER_BORDER_VAL_EN
    input  logic [DW-1:0] iBorder,
`endif
    output logic          oValid,
    input  logic          oReady,
    output logic [DW-1:0] oData,
    output logic          oDone
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam int RW = $clog2(HEIGHT + 2);

    localparam logic [CW-1:0] COL_LAST     = CW'(WIDTH + 1);
    localparam logic [CW-1:0] COL_BODY_END = CW'(WIDTH);
    localparam logic [RW-1:0] ROW_LAST     = RW'(HEIGHT + 1);
    localparam logic [RW-1:0] ROW_BODY_END = RW'(HEIGHT);

    typedef enum logic [2:0] {
        TOP,
        LEFT,
        BODY,
        RIGHT,
        BOTTOM
    } state_t;

    state_t        state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          oValid_q;
    logic [DW-1:0] oData_q;
    logic          oDone_q;

    logic          load;
    logic          beat;
    logic [DW-1:0] border_val;
    logic [DW-1:0] data_d;
    logic          done_d;

    // The output register may take a new beat when it is empty or is being drained.
    assign load   = !oValid_q || oReady;
    // Body beats need a source pixel. Border beats are produced unconditionally.
    assign beat   = (state_q == BODY) ? iValid : 1'b1;
    assign iReady = reset && load && (state_q == BODY);

    assign oValid = oValid_q;
    assign oData  = oData_q;
    assign oDone  = oDone_q;

`ifdef FRAME_PADDER_BORDER_VAL_EN
    logic [DW-1:0] border_q;

    // The first TOP beat uses iBorder directly.
    // The rest of the frame uses the captured copy.
    assign border_val = (state_q == TOP && col_q == '0) ? iBorder : border_q;

    // Capture the border colour on the first beat of each frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            border_q <= '0;
        end else if (load && state_q == TOP && col_q == '0) begin
            border_q <= iBorder;
        end
    end
`else
    assign border_val = '0;
`endif

    // Next-beat payload: source pixel in BODY, border colour everywhere else.
    always_comb begin
        data_d = (state_q == BODY) ? iData : border_val;
        done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end

    // Beat-position FSM and registered output stage, advanced only when a beat loads.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= TOP;
            col_q    <= '0;
            row_q    <= '0;
            oValid_q <= 1'b0;
            oData_q  <= '0;
            oDone_q  <= 1'b0;
        end else if (load) begin
            if (beat) begin
                oValid_q <= 1'b1;
                oData_q  <= data_d;
                oDone_q  <= done_d;
                case (state_q)
                    TOP: begin
                        if (col_q == COL_LAST) begin
                            col_q   <= '0;
                            row_q   <= RW'(1);
                            state_q <= LEFT;
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                    LEFT: begin
                        col_q   <= col_q + CW'(1);
                        state_q <= BODY;
                    end
                    BODY: begin
                        col_q <= col_q + CW'(1);
                        if (col_q == COL_BODY_END) begin
                            state_q <= RIGHT;
                        end
                    end
                    RIGHT: begin
                        col_q   <= '0;
                        row_q   <= row_q + RW'(1);
                        state_q <= (row_q < ROW_BODY_END) ? LEFT : BOTTOM;
                    end
                    BOTTOM: begin
                        if (col_q == COL_LAST) begin
                            col_q   <= '0;
                            row_q   <= '0;
                            state_q <= TOP;
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                    default: begin
                        col_q   <= '0;
                        row_q   <= '0;
                        state_q <= TOP;
                    end
                endcase
            end else begin
                // The previous beat drained and no source pixel is available.
                oValid_q <= 1'b0;
                oDone_q  <= 1'b0;
            end
        end
    end

endmodule
